// File: rtl/tlb_access_controller_if.sv
// Handshake, key-memory and frame-memory signals between the memory pipeline,
// the TLB storage and the TLB access controller.
interface tlb_access_controller_if;
    logic        requestValid;
    logic        requestReady;
    logic [31:0] requestAddress;
    logic        requestWrite;
    logic        responseValid;
    logic        responseReady;
    logic [31:0] responseAddress;
    logic        responseMiss;
    logic        responseInvalid;
    logic        responseWriteFault;
    logic [19:0] searchKey;
    logic        keyFound;
    logic [4:0]  keyFoundIndex;
    logic [4:0]  frameReadIndex;
    logic [21:0] frameReadValue;
    logic [4:0]  randomIndex;
    logic        busy;

    modport slave (
        input  requestValid, requestAddress, requestWrite, responseReady,
               keyFound, keyFoundIndex, frameReadValue,
        output requestReady, responseValid, responseAddress, responseMiss,
               responseInvalid, responseWriteFault, searchKey, frameReadIndex,
               randomIndex, busy
    );

    modport master (
        output requestValid, requestAddress, requestWrite, responseReady,
               keyFound, keyFoundIndex, frameReadValue,
        input  requestReady, responseValid, responseAddress, responseMiss,
               responseInvalid, responseWriteFault, searchKey, frameReadIndex,
               randomIndex, busy
    );
endinterface

// File: rtl/tlb_access_controller.sv
// Sequences one virtual-address translation at a time through the TLB key and
// frame memories, and owns the random-replacement refill index.
//
// state   | meaning
// IDLE    | ready to accept a translation request
// SEARCH  | key memory searched with the latched page number
// READ    | frame entry of the matching key read and checked
// RESPOND | result presented, held until the consumer takes it
module tlb_access_controller #(
    parameter int FIXED_ENTRY_COUNT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    tlb_access_controller_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        READ    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam logic [4:0] FIXED_IDX = 5'(FIXED_ENTRY_COUNT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [4:0]  frame_idx_q, frame_idx_d;
    logic [31:0] resp_addr_q, resp_addr_d;
    logic        miss_q, miss_d;
    logic        invalid_q, invalid_d;
    logic        wfault_q, wfault_d;
    logic [4:0]  rand_idx_q, rand_idx_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            frame_idx_q <= '0;
            resp_addr_q <= '0;
            miss_q      <= 1'b0;
            invalid_q   <= 1'b0;
            wfault_q    <= 1'b0;
            rand_idx_q  <= 5'd31;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            frame_idx_q <= frame_idx_d;
            resp_addr_q <= resp_addr_d;
            miss_q      <= miss_d;
            invalid_q   <= invalid_d;
            wfault_q    <= wfault_d;
            rand_idx_q  <= rand_idx_d;
        end
    end

    // Refill index wraps from the first non-fixed entry back to the top.
    always_comb begin
        rand_idx_d = rand_idx_q - 5'd1;
        if (rand_idx_q == FIXED_IDX) begin
            rand_idx_d = 5'd31;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        frame_idx_d = frame_idx_q;
        resp_addr_d = resp_addr_q;
        miss_d      = miss_q;
        invalid_d   = invalid_q;
        wfault_d    = wfault_q;

        case (state_q)
            IDLE: begin
                if (bus.requestValid) begin
                    addr_d    = bus.requestAddress;
                    write_d   = bus.requestWrite;
                    miss_d    = 1'b0;
                    invalid_d = 1'b0;
                    wfault_d  = 1'b0;
                    if (bus.requestAddress[31:30] == 2'b11) begin
                        resp_addr_d = {2'b00, bus.requestAddress[29:0]};
                        state_d     = RESPOND;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (bus.keyFound) begin
                    frame_idx_d = bus.keyFoundIndex;
                    state_d     = READ;
                end else begin
                    miss_d  = 1'b1;
                    state_d = RESPOND;
                end
            end
            READ: begin
                // Valid bit is checked before write permission so only one flag is raised.
                if (!bus.frameReadValue[0]) begin
                    invalid_d = 1'b1;
                end else if (write_q && !bus.frameReadValue[1]) begin
                    wfault_d = 1'b1;
                end else begin
                    resp_addr_d = {bus.frameReadValue[21:2], addr_q[11:0]};
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (bus.responseReady) begin
                    miss_d    = 1'b0;
                    invalid_d = 1'b0;
                    wfault_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.requestReady       = (state_q == IDLE);
    assign bus.responseValid      = (state_q == RESPOND);
    assign bus.responseAddress    = resp_addr_q;
    assign bus.responseMiss       = miss_q;
    assign bus.responseInvalid    = invalid_q;
    assign bus.responseWriteFault = wfault_q;
    assign bus.searchKey          = addr_q[31:12];
    assign bus.frameReadIndex     = frame_idx_q;
    assign bus.randomIndex        = rand_idx_q;
    assign bus.busy               = (state_q != IDLE);
endmodule

// File: tb/tb_tlb_access_controller.sv
// Directed testbench for tlb_access_controller with a one-entry key/frame memory model.
module tb_tlb_access_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic key_en = 1'b0;
    logic fr_w   = 1'b1;
    logic fr_v   = 1'b1;

    tlb_access_controller_if tif ();

    tlb_access_controller #(.FIXED_ENTRY_COUNT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif.slave)
    );

    always #5 clock = ~clock;

    // Key memory holds page 0x00400 at index 7; frame memory entry 7 maps to 0x12345.
    assign tif.keyFound       = key_en && (tif.searchKey == 20'h00400);
    assign tif.keyFoundIndex  = 5'd7;
    assign tif.frameReadValue = (tif.frameReadIndex == 5'd7) ? {20'h12345, fr_w, fr_v} : 22'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Returns cycles from acceptance edge to responseValid high (capped at 10).
    task automatic send(input logic [31:0] a, input logic w, output int lat);
        @(negedge clock);
        tif.requestValid   = 1'b1;
        tif.requestAddress = a;
        tif.requestWrite   = w;
        @(posedge clock);
        #1;
        tif.requestValid = 1'b0;
        lat = 1;
        while (!tif.responseValid && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic take(input string tag);
        @(negedge clock);
        tif.responseReady = 1'b1;
        @(posedge clock);
        #1;
        tif.responseReady = 1'b0;
        check({tag, "_valid_drop"}, {31'b0, tif.responseValid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, tif.requestReady}, 32'd1);
    endtask

    task automatic check_flags(input string tag, input logic m, input logic i, input logic wf);
        check({tag, "_miss"},   {31'b0, tif.responseMiss},       {31'b0, m});
        check({tag, "_inv"},    {31'b0, tif.responseInvalid},    {31'b0, i});
        check({tag, "_wfault"}, {31'b0, tif.responseWriteFault}, {31'b0, wf});
    endtask

    initial begin
        int lat;
        logic [4:0] exp_rand;

        tif.requestValid   = 1'b0;
        tif.requestAddress = '0;
        tif.requestWrite   = 1'b0;
        tif.responseReady  = 1'b0;

        // 1: reset values and refill index sequence
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_resp_addr", tif.responseAddress, 32'h0);
        check("rst_search_key", {12'b0, tif.searchKey}, 32'h0);
        check("rst_frame_idx", {27'b0, tif.frameReadIndex}, 32'h0);
        check("rst_busy", {31'b0, tif.busy}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        exp_rand = 5'd31;
        for (int i = 0; i < 30; i++) begin
            check("rand_idx", {27'b0, tif.randomIndex}, {27'b0, exp_rand});
            check("idle_ready", {31'b0, tif.requestReady}, 32'd1);
            check("idle_valid", {31'b0, tif.responseValid}, 32'd0);
            @(posedge clock);
            #1;
            exp_rand = (exp_rand == 5'd4) ? 5'd31 : exp_rand - 5'd1;
        end

        // 2: direct-mapped, held stable while consumer stalls
        send(32'hC0001234, 1'b0, lat);
        check("dm_latency", lat, 32'd1);
        check("dm_addr", tif.responseAddress, 32'h00001234);
        check_flags("dm", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("dm_hold_valid", {31'b0, tif.responseValid}, 32'd1);
            check("dm_hold_addr", tif.responseAddress, 32'h00001234);
            check("dm_hold_ready", {31'b0, tif.requestReady}, 32'd0);
        end
        take("dm");

        // 3: mapped store hit
        key_en = 1'b1;
        fr_w   = 1'b1;
        fr_v   = 1'b1;
        send(32'h00400ABC, 1'b1, lat);
        check("hit_latency", lat, 32'd3);
        check("hit_addr", tif.responseAddress, 32'h12345ABC);
        check_flags("hit", 1'b0, 1'b0, 1'b0);
        check("hit_frame_idx", {27'b0, tif.frameReadIndex}, 32'd7);
        check("hit_search_key", {12'b0, tif.searchKey}, 32'h00400);
        take("hit");
        check("hit_key_held", {12'b0, tif.searchKey}, 32'h00400);

        // 4: write-protect fault on store, clean load to the same entry
        fr_w = 1'b0;
        send(32'h00400ABC, 1'b1, lat);
        check("wf_latency", lat, 32'd3);
        check_flags("wf", 1'b0, 1'b0, 1'b1);
        take("wf");
        send(32'h00400ABC, 1'b0, lat);
        check("ld_latency", lat, 32'd3);
        check("ld_addr", tif.responseAddress, 32'h12345ABC);
        check_flags("ld", 1'b0, 1'b0, 1'b0);
        take("ld");

        // invalid entry outranks write-protect on a store
        fr_v = 1'b0;
        send(32'h00400ABC, 1'b1, lat);
        check("inv_latency", lat, 32'd3);
        check_flags("inv", 1'b0, 1'b1, 1'b0);
        take("inv");
        fr_v = 1'b1;
        fr_w = 1'b1;

        // 5: miss
        send(32'h7FFFF000, 1'b0, lat);
        check("miss_latency", lat, 32'd2);
        check_flags("miss", 1'b1, 1'b0, 1'b0);
        check("miss_frame_idx", {27'b0, tif.frameReadIndex}, 32'd7);
        check("miss_search_key", {12'b0, tif.searchKey}, 32'h7FFFF);
        take("miss");

        // 6: reset while in READ drops the request
        @(negedge clock);
        tif.requestValid   = 1'b1;
        tif.requestAddress = 32'h00400123;
        tif.requestWrite   = 1'b0;
        @(posedge clock);
        #1;
        tif.requestValid = 1'b0;
        @(posedge clock);
        #1;
        check("mid_busy_read", {31'b0, tif.busy}, 32'd1);
        check("mid_no_valid", {31'b0, tif.responseValid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_mid_valid", {31'b0, tif.responseValid}, 32'd0);
        check("rst_mid_busy", {31'b0, tif.busy}, 32'd0);
        check("rst_mid_rand", {27'b0, tif.randomIndex}, 32'd31);
        check("rst_mid_ready", {31'b0, tif.requestReady}, 32'd1);
        check("rst_mid_frame_idx", {27'b0, tif.frameReadIndex}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("rst_mid_no_resp", {31'b0, tif.responseValid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
